// File: rtl/mp_rf_lut_ram_np_if.sv
// Bus bundle for mp_rf_lut_ram_np: write port, NRD read ports, clear/dump control.
// The master modport drives requests; the slave modport is the register file side.
interface mp_rf_lut_ram_np_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
);
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     di;
  logic                 wr_ok;
  logic [NRD-1:0]       re;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rdata;
  logic [NRD-1:0]       rvalid;
  logic                 clr;
  logic                 dump_req;
  logic                 busy;
  logic                 dump_valid;
  logic [AW-1:0]        dump_addr;
  logic [WIDTH-1:0]     dump_data;
  logic                 dump_last;

  modport master (
    output we, wa, di, re, ra, clr, dump_req,
    input  wr_ok, rdata, rvalid, busy, dump_valid, dump_addr, dump_data, dump_last
  );

  modport slave (
    input  we, wa, di, re, ra, clr, dump_req,
    output wr_ok, rdata, rvalid, busy, dump_valid, dump_addr, dump_data, dump_last
  );
endinterface

// File: rtl/mp_rf_lut_ram_np.sv
// Multi-port LUT-RAM register file with a clear walker and streaming dump engine.
// Define RF_BYPASS_EN to forward same-cycle write data to reads and dump beats.
module mp_rf_lut_ram_np #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input logic                clk,
  input logic                rst_n,
  mp_rf_lut_ram_np_if.slave  bus
);

  typedef enum logic [1:0] {CLEAR, IDLE, DUMP} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [NRD*WIDTH-1:0]   rdata_q, rdata_d;
  logic [NRD-1:0]         rvalid_q, rvalid_d;
  logic                   dump_valid_q, dump_valid_d;
  logic                   dump_last_q, dump_last_d;
  logic [AW-1:0]          dump_addr_q, dump_addr_d;
  logic [WIDTH-1:0]       dump_data_q, dump_data_d;
  logic                   busy_q, busy_d;

  logic [WIDTH-1:0]       ram [DEPTH];
  logic                   user_wr;
  logic                   ram_we;
  logic [AW-1:0]          ram_wa;
  logic [WIDTH-1:0]       ram_wd;
  // Slice k < NRD feeds read port k; slice NRD feeds the dump engine.
  logic [(NRD+1)*WIDTH-1:0] rd_flat;

  always_comb begin
    user_wr = bus.we && (state_q != CLEAR) && (int'(bus.wa) < DEPTH);
    ram_we  = (state_q == CLEAR) || user_wr;
    ram_wa  = (state_q == CLEAR) ? ptr_q : bus.wa;
    ram_wd  = (state_q == CLEAR) ? '0 : bus.di;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  for (genvar gi = 0; gi <= NRD; gi++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] word;
    if (gi < NRD) begin : g_port
      assign addr = bus.ra[gi*AW +: AW];
    end else begin : g_dump
      assign addr = ptr_q;
    end
    always_comb begin
      word = '0;
      if (int'(addr) < DEPTH) word = ram[addr];
`ifdef RF_BYPASS_EN
      if (user_wr && (addr == bus.wa)) word = bus.di;
`endif
    end
    assign rd_flat[gi*WIDTH +: WIDTH] = word;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rdata_d      = rdata_q;
    rvalid_d     = '0;
    dump_valid_d = 1'b0;
    dump_last_d  = 1'b0;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;

    for (int k = 0; k < NRD; k++) begin
      if (bus.re[k] && (state_q != CLEAR)) begin
        rdata_d[k*WIDTH +: WIDTH] = rd_flat[k*WIDTH +: WIDTH];
        rvalid_d[k]               = 1'b1;
      end
    end

    case (state_q)
      CLEAR: begin
        if (bus.clr) begin
          ptr_d = '0;
        end else if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      IDLE: begin
        ptr_d = '0;
        if (bus.clr)           state_d = CLEAR;
        else if (bus.dump_req) state_d = DUMP;
      end
      DUMP: begin
        if (bus.clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else begin
          dump_valid_d = 1'b1;
          dump_addr_d  = ptr_q;
          dump_data_d  = rd_flat[NRD*WIDTH +: WIDTH];
          dump_last_d  = (ptr_q == LAST);
          if (ptr_q == LAST) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase

    // Keep busy up through the final dump beat, which is presented after the FSM is back in IDLE.
    busy_d = (state_d != IDLE) || dump_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      rdata_q      <= '0;
      rvalid_q     <= '0;
      dump_valid_q <= 1'b0;
      dump_last_q  <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      dump_valid_q <= dump_valid_d;
      dump_last_q  <= dump_last_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.wr_ok      = (state_q != CLEAR);
  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.busy       = busy_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_addr  = dump_addr_q;
  assign bus.dump_data  = dump_data_q;
  assign bus.dump_last  = dump_last_q;

endmodule

// File: tb/tb_mp_rf_lut_ram_np.sv
// Scoreboard bench for mp_rf_lut_ram_np (DEPTH=32, NRD=2); expected read and dump
// beats are queued at issue time and checked by a separate output monitor.
module tb_mp_rf_lut_ram_np;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [WIDTH-1:0]       q_rd0[$];
  logic [WIDTH-1:0]       q_rd1[$];
  logic [1+AW+WIDTH-1:0]  q_dump[$];

  mp_rf_lut_ram_np_if #(.WIDTH(WIDTH), .AW(AW), .NRD(NRD)) bus ();

  mp_rf_lut_ram_np #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", name, act, $time);
    end
  endtask

  // Output monitor: pops one expectation per presented read or dump beat.
  always @(negedge clk) begin
    if (bus.rvalid[0]) begin
      if (q_rd0.size() == 0) chk("rd0_unexpected", {32'd0, bus.rdata[31:0]}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("rd0_data", {32'd0, bus.rdata[31:0]}, {32'd0, q_rd0.pop_front()});
    end
    if (bus.rvalid[1]) begin
      if (q_rd1.size() == 0) chk("rd1_unexpected", {32'd0, bus.rdata[63:32]}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("rd1_data", {32'd0, bus.rdata[63:32]}, {32'd0, q_rd1.pop_front()});
    end
    if (bus.dump_valid) begin
      if (q_dump.size() == 0)
        chk("dump_unexpected", {26'd0, bus.dump_last, bus.dump_addr, bus.dump_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else
        chk("dump_beat", {26'd0, bus.dump_last, bus.dump_addr, bus.dump_data}, {26'd0, q_dump.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d);
    bus.we = 1'b1; bus.wa = AW'(a); bus.di = d;
    step();
    bus.we = 1'b0;
  endtask

  task automatic rd1(input int a, input logic [WIDTH-1:0] e);
    bus.re = 2'b01; bus.ra[4:0] = AW'(a);
    q_rd0.push_back(e);
    step();
    bus.re = 2'b00;
  endtask

  task automatic rd2(input int a0, input int a1, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1);
    bus.re = 2'b11; bus.ra = {AW'(a1), AW'(a0)};
    q_rd0.push_back(e0);
    q_rd1.push_back(e1);
    step();
    bus.re = 2'b00;
  endtask

  // Counts cycles with busy high starting from the current one; optionally tries a write mid-clear.
  task automatic measure(input int write_at, output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      if (n == write_at) begin
        bus.we = 1'b1; bus.wa = 5'd3; bus.di = 32'h5555_5555;
        chk("clear_wr_ok_low", {63'd0, bus.wr_ok}, 64'd0);
      end else begin
        bus.we = 1'b0;
      end
      n++;
      step();
    end
    bus.we = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.we = 1'b0; bus.wa = '0; bus.di = '0;
    bus.re = '0; bus.ra = '0; bus.clr = 1'b0; bus.dump_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata",      {1'b0, bus.rdata}, 64'd0);
    chk("rst_rvalid",     {62'd0, bus.rvalid}, 64'd0);
    chk("rst_dump_valid", {63'd0, bus.dump_valid}, 64'd0);
    chk("rst_dump_addr",  {59'd0, bus.dump_addr}, 64'd0);
    chk("rst_dump_data",  {32'd0, bus.dump_data}, 64'd0);
    chk("rst_dump_last",  {63'd0, bus.dump_last}, 64'd0);
    chk("rst_busy",       {63'd0, bus.busy}, 64'd1);
    chk("rst_wr_ok",      {63'd0, bus.wr_ok}, 64'd0);

    rst_n = 1'b1;
    measure(-1, n);
    chk("reset_clear_cycles", 64'(n), 64'd32);
    chk("idle_wr_ok", {63'd0, bus.wr_ok}, 64'd1);

    for (int i = 0; i < DEPTH; i++) rd2(i, DEPTH - 1 - i, 32'd0, 32'd0);

    wr(5, 32'hDEAD_BEEF);
    rd2(5, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Same-cycle write and read of address 7.
    wr(7, 32'h0000_AAAA);
    bus.we = 1'b1; bus.wa = 5'd7; bus.di = 32'h0000_1234;
    bus.re = 2'b01; bus.ra[4:0] = 5'd7;
`ifdef RF_BYPASS_EN
    q_rd0.push_back(32'h0000_1234);
`else
    q_rd0.push_back(32'h0000_AAAA);
`endif
    step();
    bus.we = 1'b0; bus.re = 2'b00;
    rd1(7, 32'h0000_1234);

    // Full dump of i+0x100.
    for (int i = 0; i < DEPTH; i++) wr(i, 32'(i + 'h100));
    for (int i = 0; i < DEPTH; i++)
      q_dump.push_back({(i == DEPTH - 1), AW'(i), 32'(i + 'h100)});
    bus.dump_req = 1'b1;
    step();
    bus.dump_req = 1'b0;
    repeat (DEPTH) @(posedge clk);
    #1;
    chk("dump_busy_last_beat", {63'd0, bus.busy}, 64'd1);
    step();
    chk("dump_busy_after",  {63'd0, bus.busy}, 64'd0);
    chk("dump_valid_after", {63'd0, bus.dump_valid}, 64'd0);

    // Dump aborted by clr while beat 10 is presented.
    for (int i = 0; i <= 10; i++) q_dump.push_back({1'b0, AW'(i), 32'(i + 'h100)});
    bus.dump_req = 1'b1;
    step();
    bus.dump_req = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk("abort_dump_valid", {63'd0, bus.dump_valid}, 64'd0);
    chk("abort_dump_last",  {63'd0, bus.dump_last}, 64'd0);
    measure(20, n);
    chk("abort_clear_cycles", 64'(n), 64'd32);
    rd1(3, 32'd0);
    rd2(10, 31, 32'd0, 32'd0);

    // Reset pulse in the middle of a dump.
    wr(4, 32'h0000_0444);
    for (int i = 0; i < 5; i++) q_dump.push_back({1'b0, AW'(i), (i == 4) ? 32'h0000_0444 : 32'd0});
    bus.dump_req = 1'b1;
    step();
    bus.dump_req = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dump_valid", {63'd0, bus.dump_valid}, 64'd0);
    chk("rst_mid_dump_busy",  {63'd0, bus.busy}, 64'd1);
    step();
    rst_n = 1'b1;
    measure(-1, n);
    chk("rst_dump_clear_cycles", 64'(n), 64'd32);
    rd1(4, 32'd0);

    // Reset pulse while the clear walker sits at ptr 20.
    wr(25, 32'h0000_0077);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    measure(-1, n);
    chk("rst_clear_cycles", 64'(n), 64'd32);
    rd2(25, 5, 32'd0, 32'd0);

    repeat (3) step();
    chk("rd0_queue_drained",  64'(q_rd0.size()), 64'd0);
    chk("rd1_queue_drained",  64'(q_rd1.size()), 64'd0);
    chk("dump_queue_drained", 64'(q_dump.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
